// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage in front of the MIPS ALU: decodes one instruction into the ALU
// selectors and operands, then holds it in a two-entry main/skid buffer toward EX.
module alu_issue_stage #(
   parameter int DATA_W = 32
) (
   input  logic              in_clk,
   input  logic              in_reset,
   input  logic              in_valid,
   output logic              out_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_rs_val,
   input  logic [DATA_W-1:0] in_rt_val,
   input  logic              in_flush,
   output logic              out_valid,
   input  logic              in_ready,
   output logic [1:0]        out_op_type_1,
   output logic [1:0]        out_op_type_2,
   output logic              out_op_type_3,
   output logic [DATA_W-1:0] out_1,
   output logic [DATA_W-1:0] out_2,
   output logic [4:0]        out_rd,
   output logic              out_ovf_chk,
   output logic              out_illegal
);

   typedef struct packed {
      logic              illegal;
      logic [1:0]        t1;
      logic [1:0]        t2;
      logic              t3;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [4:0]        rd;
      logic              ovf;
   } issue_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

   localparam logic [DATA_W-1:0] SIGN = {1'b1, {(DATA_W-1){1'b0}}};

   logic [5:0]        op;
   logic [5:0]        funct;
   logic [DATA_W-1:0] shamt;
   logic [DATA_W-1:0] imm_s;
   logic [DATA_W-1:0] imm_z;
   logic              legal;
   logic              unused_bits;
   issue_t            dec;
   issue_t            main_q;
   issue_t            skid_q;
   buf_state_t        state;
   logic              accept;
   logic              issue;

   assign op          = in_instr[31:26];
   assign funct       = in_instr[5:0];
   assign shamt       = {{(DATA_W-5){1'b0}}, in_instr[10:6]};
   assign imm_s       = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
   assign imm_z       = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
   assign unused_bits = ^in_instr[25:22];

   // The SLT forms flip the sign bit so the ALU's unsigned compare behaves as signed.
   always_comb begin
      dec   = '0;
      legal = 1'b1;
      case (op)
         6'h00: begin
            dec.rd = in_instr[15:11];
            case (funct)
               6'h00: begin dec.op1 = in_rt_val; dec.op2 = shamt; end
               6'h02: begin dec.t2 = {1'b0, in_instr[21]}; dec.t3 = 1'b1; dec.op1 = in_rt_val; dec.op2 = shamt; end
               6'h03: begin dec.t2 = 2'b10; dec.t3 = 1'b1; dec.op1 = in_rt_val; dec.op2 = shamt; end
               6'h04: begin dec.op1 = in_rt_val; dec.op2 = in_rs_val; end
               6'h06: begin dec.t2 = {1'b0, in_instr[6]}; dec.t3 = 1'b1; dec.op1 = in_rt_val; dec.op2 = in_rs_val; end
               6'h07: begin dec.t2 = 2'b10; dec.t3 = 1'b1; dec.op1 = in_rt_val; dec.op2 = in_rs_val; end
               6'h20, 6'h21: begin dec.t1 = 2'b10; dec.ovf = ~funct[0]; dec.op1 = in_rs_val; dec.op2 = in_rt_val; end
               6'h22, 6'h23: begin dec.t1 = 2'b10; dec.t2 = 2'b01; dec.ovf = ~funct[0]; dec.op1 = in_rs_val; dec.op2 = in_rt_val; end
               6'h24: begin dec.t1 = 2'b11; dec.op1 = in_rs_val; dec.op2 = in_rt_val; end
               6'h25: begin dec.t1 = 2'b11; dec.t2 = 2'b01; dec.op1 = in_rs_val; dec.op2 = in_rt_val; end
               6'h26: begin dec.t1 = 2'b11; dec.t2 = 2'b11; dec.op1 = in_rs_val; dec.op2 = in_rt_val; end
               6'h27: begin dec.t1 = 2'b11; dec.t2 = 2'b10; dec.op1 = in_rs_val; dec.op2 = in_rt_val; end
               6'h2A: begin dec.t1 = 2'b01; dec.op1 = in_rs_val ^ SIGN; dec.op2 = in_rt_val ^ SIGN; end
               6'h2B: begin dec.t1 = 2'b01; dec.op1 = in_rs_val; dec.op2 = in_rt_val; end
               default: legal = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin
            dec.rd = in_instr[20:16]; dec.t1 = 2'b10; dec.ovf = ~op[0];
            dec.op1 = in_rs_val; dec.op2 = imm_s;
         end
         6'h0A: begin dec.rd = in_instr[20:16]; dec.t1 = 2'b01; dec.op1 = in_rs_val ^ SIGN; dec.op2 = imm_s ^ SIGN; end
         6'h0B: begin dec.rd = in_instr[20:16]; dec.t1 = 2'b01; dec.op1 = in_rs_val; dec.op2 = imm_s; end
         6'h0C: begin dec.rd = in_instr[20:16]; dec.t1 = 2'b11; dec.op1 = in_rs_val; dec.op2 = imm_z; end
         6'h0D: begin dec.rd = in_instr[20:16]; dec.t1 = 2'b11; dec.t2 = 2'b01; dec.op1 = in_rs_val; dec.op2 = imm_z; end
         6'h0E: begin dec.rd = in_instr[20:16]; dec.t1 = 2'b11; dec.t2 = 2'b11; dec.op1 = in_rs_val; dec.op2 = imm_z; end
         6'h0F: begin dec.rd = in_instr[20:16]; dec.op1 = imm_z; dec.op2 = DATA_W'(16); end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec         = '0;
         dec.t1      = 2'b11;
         dec.illegal = 1'b1;
      end
   end

   assign accept = in_valid & out_ready;
   assign issue  = out_valid & in_ready;

   // Main register always feeds the ALU; the skid only fills when main is stalled.
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_ready <= 1'b1;
         main_q    <= '0;
         skid_q    <= '0;
      end else if (in_flush) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_ready <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_q    <= dec;
                  state     <= ONE;
                  out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (accept && issue) begin
                  main_q <= dec;
               end else if (accept) begin
                  skid_q    <= dec;
                  state     <= TWO;
                  out_ready <= 1'b0;
               end else if (issue) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            TWO: begin
               if (issue) begin
                  main_q    <= skid_q;
                  state     <= ONE;
                  out_ready <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               out_ready <= 1'b1;
            end
         endcase
      end
   end

   assign out_op_type_1 = main_q.t1;
   assign out_op_type_2 = main_q.t2;
   assign out_op_type_3 = main_q.t3;
   assign out_1         = main_q.op1;
   assign out_2         = main_q.op2;
   assign out_rd        = main_q.rd;
   assign out_ovf_chk   = main_q.ovf;
   assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected decodes are queued on accept and
// compared against the ALU-side fields whenever the stage presents an entry.
module tb_alu_issue_stage;

   logic        in_clk = 1'b0;
   logic        in_reset;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs_val;
   logic [31:0] in_rt_val;
   logic        in_flush;
   logic        out_valid;
   logic        in_ready;
   logic [1:0]  out_op_type_1;
   logic [1:0]  out_op_type_2;
   logic        out_op_type_3;
   logic [31:0] out_1;
   logic [31:0] out_2;
   logic [4:0]  out_rd;
   logic        out_ovf_chk;
   logic        out_illegal;

   alu_issue_stage #(.DATA_W(32)) dut (
      .in_clk(in_clk), .in_reset(in_reset), .in_valid(in_valid), .out_ready(out_ready),
      .in_instr(in_instr), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_flush(in_flush),
      .out_valid(out_valid), .in_ready(in_ready), .out_op_type_1(out_op_type_1),
      .out_op_type_2(out_op_type_2), .out_op_type_3(out_op_type_3), .out_1(out_1), .out_2(out_2),
      .out_rd(out_rd), .out_ovf_chk(out_ovf_chk), .out_illegal(out_illegal)
   );

   always #5 in_clk = ~in_clk;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          issued = 0;
   bit          accepted = 1'b0;
   logic [75:0] sbq[$];
   logic [75:0] pending_exp;
   logic [5:0]  r_functs [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                   6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h01};
   logic [5:0]  i_ops [10]    = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                   6'h3F, 6'h02};

   wire [75:0] observed = {out_illegal, out_op_type_1, out_op_type_2, out_op_type_3,
                           out_1, out_2, out_rd, out_ovf_chk};

   // Reference decode, packed as {illegal, t1, t2, t3, out_1, out_2, rd, ovf}.
   function automatic logic [75:0] exp_of(input logic [31:0] ins, input logic [31:0] rs,
                                          input logic [31:0] rt);
      logic [5:0]  op, fn;
      logic        ill, c, v;
      logic [1:0]  a, b;
      logic [31:0] x, y, simm, zimm, sh;
      logic [4:0]  d;
      op = ins[31:26]; fn = ins[5:0];
      ill = 1'b0; a = 2'b00; b = 2'b00; c = 1'b0; v = 1'b0; x = '0; y = '0; d = '0;
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'h0000, ins[15:0]};
      sh   = {27'd0, ins[10:6]};
      if (op == 6'h00) begin
         d = ins[15:11];
         if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03 || fn == 6'h04 || fn == 6'h06 || fn == 6'h07) begin
            x = rt;
            y = fn[2] ? rs : sh;
            c = fn[1];
            if (fn[1:0] == 2'b11) b = 2'b10;
            else if (fn[1:0] == 2'b10 && (fn[2] ? ins[6] : ins[21])) b = 2'b01;
         end else if (fn >= 6'h20 && fn <= 6'h23) begin
            a = 2'b10; b = {1'b0, fn[1]}; v = ~fn[0]; x = rs; y = rt;
         end else if (fn >= 6'h24 && fn <= 6'h27) begin
            a = 2'b11; x = rs; y = rt;
            case (fn[1:0])
               2'b00: b = 2'b00;
               2'b01: b = 2'b01;
               2'b10: b = 2'b11;
               default: b = 2'b10;
            endcase
         end else if (fn == 6'h2A || fn == 6'h2B) begin
            a = 2'b01;
            x = fn[0] ? rs : {~rs[31], rs[30:0]};
            y = fn[0] ? rt : {~rt[31], rt[30:0]};
         end else begin
            ill = 1'b1;
         end
      end else begin
         d = ins[20:16]; x = rs;
         case (op)
            6'h08: begin a = 2'b10; y = simm; v = 1'b1; end
            6'h09: begin a = 2'b10; y = simm; end
            6'h0A: begin a = 2'b01; x = {~rs[31], rs[30:0]}; y = {~simm[31], simm[30:0]}; end
            6'h0B: begin a = 2'b01; y = simm; end
            6'h0C: begin a = 2'b11; y = zimm; end
            6'h0D: begin a = 2'b11; b = 2'b01; y = zimm; end
            6'h0E: begin a = 2'b11; b = 2'b11; y = zimm; end
            6'h0F: begin x = zimm; y = 32'd16; end
            default: ill = 1'b1;
         endcase
      end
      if (ill) return {1'b1, 2'b11, 73'd0};
      return {ill, a, b, c, x, y, d, v};
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      int          k;
      r = $urandom;
      k = $urandom_range(0, 25);
      if (k < 16) return {6'h00, r[25:6], r_functs[k]};
      return {i_ops[k-16], r[25:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [75:0] obs, input logic [75:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // One clock: compare the presented entry, then account for this cycle's accept.
   task automatic tick();
      logic [75:0] head;
      @(negedge in_clk);
      accepted = 1'b0;
      checkOutput("valid_flag", {75'd0, out_valid}, {75'd0, sbq.size() != 0});
      checkOutput("ready_flag", {75'd0, out_ready}, {75'd0, sbq.size() < 2});
      if (out_valid && sbq.size() != 0) begin
         if (in_ready && !in_reset && !in_flush) begin
            head = sbq.pop_front();
            checkOutput("issue", observed, head);
            issued++;
         end else begin
            checkOutput("hold", observed, sbq[0]);
         end
      end
      if (in_reset || in_flush) begin
         sbq.delete();
      end else if (in_valid && out_ready) begin
         sbq.push_back(pending_exp);
         accepted = 1'b1;
      end
      @(posedge in_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [75:0] exp);
      in_valid = 1'b1; in_instr = ins; in_rs_val = rs; in_rt_val = rt; pending_exp = exp;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (accepted) break;
      end
      checkOutput("accept_timeout", {75'd0, accepted}, 76'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0; in_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (sbq.size() == 0 && !out_valid) break;
         tick();
      end
      checkOutput("drain", 76'(sbq.size()), 76'd0);
   endtask

   task automatic applyRandom(input logic [31:0] ins);
      logic [31:0] rs, rt;
      rs = $urandom; rt = $urandom;
      applyStimulus(ins, rs, rt, exp_of(ins, rs, rt));
   endtask

   initial begin
      int base;
      logic [31:0] rs, rt;
      in_reset = 1'b1; in_valid = 1'b1; in_flush = 1'b0; in_ready = 1'b0;
      in_instr = 32'h2128FFFF; in_rs_val = 32'd5; in_rt_val = 32'd0; pending_exp = '0;
      tick(); tick();
      in_reset = 1'b0; in_valid = 1'b0;
      checkOutput("reset_payload", observed, 76'd0);
      checkOutput("reset_valid", {75'd0, out_valid}, 76'd0);
      checkOutput("reset_ready", {75'd0, out_ready}, 76'd1);

      in_ready = 1'b1;
      applyStimulus(32'h2128FFFF, 32'd5, 32'd0,
                    {1'b0, 2'b10, 2'b00, 1'b0, 32'd5, 32'hFFFFFFFF, 5'd8, 1'b1});
      checkOutput("latency", {75'd0, out_valid}, 76'd1);
      applyStimulus(32'h0022182A, 32'hFFFFFFFF, 32'd1,
                    {1'b0, 2'b01, 2'b00, 1'b0, 32'h7FFFFFFF, 32'h80000001, 5'd3, 1'b0});
      applyStimulus(32'h3C0A1234, 32'hDEADBEEF, 32'd7,
                    {1'b0, 2'b00, 2'b00, 1'b0, 32'h00001234, 32'd16, 5'd10, 1'b0});
      applyStimulus(32'h00200902, 32'h11111111, 32'hA5A5A5A5,
                    {1'b0, 2'b00, 2'b01, 1'b1, 32'hA5A5A5A5, 32'd4, 5'd1, 1'b0});
      applyStimulus(32'hFC000000, 32'h12345678, 32'h9ABCDEF0, {1'b1, 2'b11, 73'd0});
      drain();

      // Stall: A and B fill the buffer, C must wait until the ALU drains.
      base = issued;
      in_ready = 1'b0;
      applyRandom(gen_instr());
      applyRandom(gen_instr());
      checkOutput("ready_low", {75'd0, out_ready}, 76'd0);
      in_instr = gen_instr(); rs = $urandom; rt = $urandom;
      in_rs_val = rs; in_rt_val = rt; in_valid = 1'b1;
      pending_exp = exp_of(in_instr, rs, rt);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("c_held", {75'd0, accepted}, 76'd0);
      end
      in_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (accepted) break;
      end
      checkOutput("c_accept", {75'd0, accepted}, 76'd1);
      drain();
      checkOutput("abc_once", 76'(issued - base), 76'd3);

      // Flush from TWO with a live request on the input.
      in_ready = 1'b0;
      applyRandom(gen_instr());
      applyRandom(gen_instr());
      in_valid = 1'b1; in_flush = 1'b1; in_instr = 32'h2128FFFF;
      tick();
      in_flush = 1'b0; in_valid = 1'b0;
      checkOutput("flush_valid", {75'd0, out_valid}, 76'd0);
      checkOutput("flush_ready", {75'd0, out_ready}, 76'd1);
      base = issued;
      in_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("flush_no_issue", 76'(issued - base), 76'd0);

      // Random traffic with random back-pressure and occasional flushes.
      in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || accepted) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = gen_instr(); rs = $urandom; rt = $urandom;
            in_rs_val = rs; in_rt_val = rt;
            pending_exp = exp_of(in_instr, rs, rt);
         end
         in_ready = ($urandom_range(0, 3) != 0);
         in_flush = ($urandom_range(0, 63) == 0);
         tick();
      end
      in_flush = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that sits directly upstream of the MIPS ALU. It takes one instruction word plus its two register-file read values per accepted transfer and decodes the opcode/funct fields into the ALU's three operation-type selectors. It then selects and extends the operands and holds the result in a two-entry valid/ready buffer that drives the ALU inputs. It also forwards the destination register number and an overflow-trap qualifier to the write-back side.

## Interface
- DATA_W, 32, operand width; only 32 is supported.
- in_clk  input  1  clock; all state updates on the rising edge.
- in_reset  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream has an instruction.
- out_ready  output  1  stage can accept; registered.
- in_instr  input  32  MIPS instruction word.
- in_rs_val  input  32  register value for instr[25:21].
- in_rt_val  input  32  register value for instr[20:16].
- in_flush  input  1  discard all buffered and incoming instructions.
- out_valid  output  1  ALU-side fields are valid.
- in_ready  input  1  ALU/EX side consumes this cycle.
- out_op_type_1  output  2  ALU selector 1: 00 shift, 01 SLT, 10 arith, 11 logic.
- out_op_type_2  output  2  ALU selector 2.
- out_op_type_3  output  1  shift direction: 0 left, 1 right.
- out_1  output  32  ALU input 1.
- out_2  output  32  ALU input 2.
- out_rd  output  5  destination register.
- out_ovf_chk  output  1  1 = ALU overflow flag must trap (add, sub, addi).
- out_illegal  output  1  instruction not decodable.

## Operation
- Decode is per instruction, with fields {t1, t2, t3, out_1, out_2, rd, ovf}. Unlisted fields are 0. Shamt is zero-extended instr[10:6].
- R-type (opcode 0), rd=instr[15:11]:
  - sll 00: {00,00,0, rt, shamt}.
  - srl 02: {00,00,1, rt, shamt}. With instr[21]=1 it is rotr: t2=01.
  - sra 03: {00,10,1, rt, shamt}.
  - sllv 04, srlv 06, sra v 07: as the immediate shifts, but out_2=rs. srlv with instr[6]=1 is rotrv: t2=01.
  - add 20 and addu 21: {10,00}. sub 22 and subu 23: {10,01}. ovf=1 only for add and sub.
  - and 24 {11,00}; or 25 {11,01}; xor 26 {11,11}; nor 27 {11,10}.
  - sltu 2B: {01, rs, rt}. slt 2A: {01, rs^0x80000000, rt^0x80000000}. The sign flip turns the ALU's unsigned compare into a signed one.
- I-type, rd=instr[20:16], out_1=rs:
  - addi 08 (ovf=1) and addiu 09: {10,00}, imm sign-extended.
  - slti 0A: imm sign-extended, both operands sign-flipped. sltiu 0B: imm sign-extended, no flip.
  - andi 0C, ori 0D, xori 0E: logic, imm zero-extended.
  - lui 0F: {00,00,0, out_1=zero-ext imm, out_2=16}.
- Any other opcode or funct: out_illegal=1, {11,00}, operands 0, rd 0, ovf 0. The entry still flows through the handshake.
- Buffer states:
  - EMPTY: no entry held.
  - ONE: main register full.
  - TWO: main register and skid register full.
- Transfer rules:
  - Accept = in_valid & out_ready. Issue = out_valid & in_ready.
  - Outputs always come from the main register.
  - On issue, skid moves into main.
  - An accept goes to main if main is empty or issuing that cycle, otherwise to skid.
- State transitions:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on issue without accept. ONE -> TWO on accept without issue. ONE stays ONE on both or neither.
  - TWO -> ONE on issue (no accept is possible in TWO).
- out_ready = (next state != TWO).
- Program order is strictly preserved; no entry is lost or duplicated.

## Timing
- Reset values: out_valid 0, out_ready 1, all data and selector outputs 0, state EMPTY. in_valid is ignored while in_reset=1.
- Latency: instruction accepted at edge N is on the outputs with out_valid=1 after edge N. Throughput is 1 per cycle while in_ready=1.
- out_ready falls in the cycle after the second un-issued accept. It rises in the cycle after an issue from TWO.
- in_flush (synchronous): after the edge, state is EMPTY, out_valid 0, out_ready 1. An accept in the flush cycle is discarded.
- Reset has priority over flush; flush has priority over accept and issue.
- Outputs are stable while out_valid=1 and in_ready=0.

## Test plan
- addi 0x2128FFFF, rs_val=5 -> one cycle later: out_1=5, out_2=0xFFFFFFFF, {10,00}, rd=8, ovf=1.
- slt 0x0022182A, rs=0xFFFFFFFF, rt=1 -> out_1=0x7FFFFFFF, out_2=0x80000001, t1=01, rd=3. The downstream ALU must give slt=1.
- lui 0x3C0A1234 -> out_1=0x00001234, out_2=16, {00,00,0}, rd=10. Also rotr 0x00200902 (rt=0, shamt=4, rd=1) -> t2=01, t3=1.
- in_ready=0, three back-to-back instructions A, B, C -> A and B accepted, out_ready=0 the next cycle, C held. Release in_ready -> A, B, C issued in order, once each.
- State TWO with in_valid=1 and in_flush=1 -> next cycle out_valid=0, out_ready=1. None of the flushed instructions ever issues.
- 0xFC000000 -> out_illegal=1, {11,00}, out_1=out_2=0, rd=0, issued normally.
